msu_data_fetch: RTL

//  Serves the MSU-1 data track to the MSU register block: turns seek/advance requests

---
 rtl/msu_data_fetch.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/msu_data_fetch.sv
// msu_data_fetch
//   Streams the MSU-1 data track to the MSU register block. Seek and advance
//   requests become sector reads over the HPS SD block interface. A 1 KiB
//   two-half buffer holds the current sector, and the next sector is
//   prefetched into the other half.
// Ports
//   CLK, RESET                  clock, asynchronous active-high reset
//   msu_data_addr               byte address in the data track
//   msu_data_seek               seek level, held high until msu_data_ack
//   msu_data_req                advance pulse (address already incremented)
//   msu_data                    registered byte at the current address
//   msu_data_ack                one-cycle seek-complete pulse
//   underrun                    sticky: advance reached an unloaded sector
//   sd_lba, sd_rd               sector read request to the HPS
//   sd_ack, sd_buff_addr,
//   sd_buff_dout, sd_buff_wr    sector transfer from the HPS
module msu_data_fetch #(
    parameter int PREFETCH = 1,
    parameter int LBA_W    = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [31:0]      msu_data_addr,
    input  logic             msu_data_seek,
    input  logic             msu_data_req,
    output logic [7:0]       msu_data,
    output logic             msu_data_ack,
    output logic             underrun,
    output logic [LBA_W-1:0] sd_lba,
    output logic             sd_rd,
    input  logic             sd_ack,
    input  logic [8:0]       sd_buff_addr,
    input  logic [7:0]       sd_buff_dout,
    input  logic             sd_buff_wr
);

    typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

    state_t      state;
    logic [31:0] cur_addr;
    logic [22:0] target;
    logic [22:0] tag [2];
    logic [1:0]  valid;
    logic        seek_d;
    logic        seek_pending;
    logic        wait_cnt;
    logic        discard;
    logic        armed;
    logic [7:0]  buf_mem [1024];
    logic [7:0]  rd_q;
    logic        rd_ok;

    logic        seek_rise;
    logic        adv;
    logic        buf_we;
    logic [22:0] cur_sec;
    logic [22:0] nxt_sec;
    logic [22:0] req_sec;
    logic        cur_hit;
    logic        nxt_hit;
    logic        req_hit;

    // Seek has priority over an advance in the same cycle.
    assign seek_rise = msu_data_seek & ~seek_d;
    assign adv       = msu_data_req & ~seek_rise;

    // Sector numbers are 23 bits, so S+1 wraps from 0x7FFFFF to 0.
    assign cur_sec = cur_addr[31:9];
    assign nxt_sec = cur_sec + 23'd1;
    assign req_sec = msu_data_addr[31:9];
    assign cur_hit = valid[cur_sec[0]] && (tag[cur_sec[0]] == cur_sec);
    assign nxt_hit = valid[nxt_sec[0]] && (tag[nxt_sec[0]] == nxt_sec);
    assign req_hit = valid[req_sec[0]] && (tag[req_sec[0]] == req_sec);

    assign sd_lba = LBA_W'(target);

    // Bytes land in the half selected by the sector parity. Strobes are
    // ignored outside XFER (including after a reset) and for discarded reads.
    assign buf_we = sd_buff_wr && sd_ack && (state == XFER) && !discard;

    always_ff @(posedge CLK) begin
        if (buf_we)
            buf_mem[{target[0], sd_buff_addr}] <= sd_buff_dout;
        rd_q <= buf_mem[cur_addr[9:0]];
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state        <= IDLE;
            cur_addr     <= '0;
            target       <= '0;
            for (int unsigned i = 0; i < 2; i++)
                tag[i] <= '0;
            valid        <= '0;
            seek_d       <= 1'b0;
            seek_pending <= 1'b0;
            wait_cnt     <= 1'b0;
            discard      <= 1'b0;
            armed        <= 1'b0;
            rd_ok        <= 1'b0;
            msu_data     <= '0;
            msu_data_ack <= 1'b0;
            underrun     <= 1'b0;
            sd_rd        <= 1'b0;
        end else begin
            seek_d       <= msu_data_seek;
            msu_data_ack <= 1'b0;

            // Two-stage read: RAM output, then msu_data. msu_data only moves
            // when the addressed sector is loaded, so it holds during underrun.
            rd_ok <= cur_hit;
            if (rd_ok)
                msu_data <= rd_q;

            case (state)
                IDLE: begin
                    if (armed && !seek_rise && !msu_data_req) begin
                        if (!cur_hit) begin
                            state             <= REQ;
                            sd_rd             <= 1'b1;
                            target            <= cur_sec;
                            valid[cur_sec[0]] <= 1'b0;
                        end else if (PREFETCH != 0 && !seek_pending && !nxt_hit) begin
                            state             <= REQ;
                            sd_rd             <= 1'b1;
                            target            <= nxt_sec;
                            valid[nxt_sec[0]] <= 1'b0;
                        end
                    end
                end
                REQ: begin
                    if (sd_ack) begin
                        state <= XFER;
                        sd_rd <= 1'b0;
                    end
                end
                XFER: begin
                    if (!sd_ack)
                        state <= DONE;
                end
                DONE: begin
                    state   <= IDLE;
                    discard <= 1'b0;
                    if (!discard) begin
                        valid[target[0]] <= 1'b1;
                        tag[target[0]]   <= target;
                    end
                end
                default: state <= IDLE;
            endcase

            // Seek completes two cycles after its sector becomes readable,
            // the same edge msu_data picks up the byte.
            if (seek_pending && cur_hit) begin
                if (wait_cnt) begin
                    msu_data_ack <= 1'b1;
                    seek_pending <= 1'b0;
                    wait_cnt     <= 1'b0;
                end else begin
                    wait_cnt <= 1'b1;
                end
            end

            if (adv) begin
                cur_addr <= msu_data_addr;
                if (req_sec != cur_sec && !req_hit)
                    underrun <= 1'b1;
            end

            // Seek overrides everything above. A sector finishing in this very
            // cycle stays valid only if it is the new seek target.
            if (seek_rise) begin
                cur_addr     <= msu_data_addr;
                underrun     <= 1'b0;
                seek_pending <= 1'b1;
                wait_cnt     <= 1'b0;
                msu_data_ack <= 1'b0;
                armed        <= 1'b1;
                valid        <= '0;
                if (state == DONE && !discard && target == req_sec)
                    valid[target[0]] <= 1'b1;
                case (state)
                    REQ: begin
                        if (sd_ack)
                            discard <= 1'b1;
                        else
                            target <= req_sec;
                    end
                    XFER:    discard <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule
